rx_stat_counters: RTL and testbench



---
 rtl/rx_stat_pkg.sv | 35 +++
 rtl/rx_stat_counter.sv | 38 +++
 rtl/rx_stat_counters.sv | 103 ++++++++++
 tb/tb_rx_stat_counters.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_stat_pkg.sv
// Shared definitions for the receive statistics counter bank.
// Latency: none (constants and a pure helper function).
// Backpressure: not applicable.
package rx_stat_pkg;

  localparam int RX_STAT_NUM = 18;

  localparam int STAT_GOOD      = 0;
  localparam int STAT_FCS       = 1;
  localparam int STAT_BCAST     = 2;
  localparam int STAT_MCAST     = 3;
  localparam int STAT_64        = 4;
  localparam int STAT_65_127    = 5;
  localparam int STAT_128_255   = 6;
  localparam int STAT_256_511   = 7;
  localparam int STAT_512_1023  = 8;
  localparam int STAT_1024_MAX  = 9;
  localparam int STAT_CTRL      = 10;
  localparam int STAT_LEN_RANGE = 11;
  localparam int STAT_PAUSE     = 12;
  localparam int STAT_UNSUP_OP  = 13;
  localparam int STAT_OVERSIZE  = 14;
  localparam int STAT_UNDERSIZE = 15;
  localparam int STAT_FRAG      = 16;
  localparam int STAT_BYTES     = 17;

  // Strobe positions that have no counter behind them.
  localparam logic [RX_STAT_NUM-1:0] STAT_UNUSED_MASK = 18'(1) << STAT_UNSUP_OP;

  // True when a host read address maps onto a real counter.
  function automatic logic stat_addr_valid(input logic [4:0] addr);
    return (int'(addr) < RX_STAT_NUM) && (int'(addr) != STAT_UNSUP_OP);
  endfunction

endpackage

// File: rtl/rx_stat_counter.sv
// One wrapping statistics counter with a sticky carry-out flag.
// Latency: increment and clear take effect on the next rising edge.
// Backpressure: none; an increment is applied on every cycle it is presented.
module rx_stat_counter #(
  parameter int CNT_W = 48
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [3:0]       inc_amt,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] base;
  logic             ovf_base;
  logic [CNT_W:0]   sum;

  // Clear replaces the old value with zero but still lets this cycle's increment in.
  always_comb begin
    base     = clr ? '0 : cnt;
    ovf_base = clr ? 1'b0 : ovf;
    sum      = {1'b0, base} + {{(CNT_W-3){1'b0}}, (inc_en ? inc_amt : 4'd0)};
  end

  // Counter register; a carry out of the MSB latches into the sticky flag.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= sum[CNT_W-1:0];
      ovf <= ovf_base | sum[CNT_W];
    end
  end

endmodule

// File: rtl/rx_stat_counters.sv
// Receive statistics bank: 17 wide counters fed by registered per-frame strobes, host read port.
// Latency: strobe to counter 2 edges; read request to ack/data 1 cycle.
// Backpressure: none; reads accepted every cycle, strobes never dropped or merged.
module rx_stat_counters
  import rx_stat_pkg::*;
#(
  parameter int CNT_W       = 48,
  parameter bit CLR_ON_READ = 1'b1
) (
  input  logic                   rxclk,
  input  logic                   reset,
  input  logic [RX_STAT_NUM-1:0] rxStatRegPlus,
  input  logic [3:0]             rx_byte_count,
  input  logic                   stat_clear,
  input  logic                   stat_rd_req,
  input  logic [4:0]             stat_rd_addr,
  output logic                   stat_rd_ack,
  output logic [CNT_W-1:0]       stat_rd_data,
  output logic                   stat_rd_ovf,
  output logic                   stat_rd_err
);

  logic [RX_STAT_NUM-1:0] inc_q;
  logic [3:0]             bytes_q;
  logic [CNT_W-1:0]       cnt_arr [RX_STAT_NUM];
  logic [RX_STAT_NUM-1:0] ovf_vec;
  logic [RX_STAT_NUM-1:0] clr_vec;
  logic                   rd_valid;
  logic [CNT_W-1:0]       rd_cnt;
  logic                   rd_ovf;
  logic                   unused_bits;

  // Input stage: register strobes and byte count unconditionally.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      inc_q   <= '0;
      bytes_q <= '0;
    end else begin
      inc_q   <= rxStatRegPlus;
      bytes_q <= rx_byte_count;
    end
  end

  assign rd_valid = stat_addr_valid(stat_rd_addr);

  // Per-counter clear: global clear, or clear-on-read of the addressed counter.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < RX_STAT_NUM; i++) begin
      clr_vec[i] = stat_clear |
                   (CLR_ON_READ & stat_rd_req & rd_valid & (stat_rd_addr == 5'(i)));
    end
  end

  // Counter bank; the unused strobe position has no storage and reads as zero.
  for (genvar g = 0; g < RX_STAT_NUM; g++) begin : g_stat
    if (STAT_UNUSED_MASK[g]) begin : g_none
      assign cnt_arr[g] = '0;
      assign ovf_vec[g] = 1'b0;
    end else begin : g_ctr
      rx_stat_counter #(.CNT_W(CNT_W)) u_cnt (
        .rxclk   (rxclk),
        .reset   (reset),
        .inc_en  (inc_q[g]),
        .inc_amt ((g == STAT_BYTES) ? bytes_q : 4'd1),
        .clr     (clr_vec[g]),
        .cnt     (cnt_arr[g]),
        .ovf     (ovf_vec[g])
      );
    end
  end

  // The unused strobe and its clear line are deliberately dropped.
  assign unused_bits = |((inc_q | clr_vec) & STAT_UNUSED_MASK);

  // Read mux: selects the pre-update value of the addressed counter.
  always_comb begin
    rd_cnt = '0;
    rd_ovf = 1'b0;
    for (int i = 0; i < RX_STAT_NUM; i++) begin
      if (stat_rd_addr == 5'(i)) begin
        rd_cnt = cnt_arr[i];
        rd_ovf = ovf_vec[i];
      end
    end
  end

  // One-deep read pipeline; bad addresses return zero data with err set.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      stat_rd_ack  <= 1'b0;
      stat_rd_data <= '0;
      stat_rd_ovf  <= 1'b0;
      stat_rd_err  <= 1'b0;
    end else begin
      stat_rd_ack  <= stat_rd_req;
      stat_rd_err  <= stat_rd_req & ~rd_valid;
      stat_rd_data <= (stat_rd_req && rd_valid) ? rd_cnt : '0;
      stat_rd_ovf  <= stat_rd_req & rd_valid & rd_ovf;
    end
  end

endmodule

// File: tb/tb_rx_stat_counters.sv
// Bench for rx_stat_counters: wide clear-on-read instance plus a narrow non-destructive one.
// Both instances share stimulus; a frame-level model predicts every read result.
// Directed scenarios first, then a randomized run against the model.
module tb_rx_stat_counters;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] plus;
  logic [3:0]  nbytes;
  logic        sclr;
  logic        rd_req;
  logic [4:0]  rd_addr;

  logic        ack_m, ovf_m, err_m;
  logic [47:0] data_m;
  logic        ack_n, ovf_n, err_n;
  logic [7:0]  data_n;

  always #5 clk = ~clk;

  rx_stat_counters #(.CNT_W(48), .CLR_ON_READ(1'b1)) dut_m (
    .rxclk(clk), .reset(reset), .rxStatRegPlus(plus), .rx_byte_count(nbytes),
    .stat_clear(sclr), .stat_rd_req(rd_req), .stat_rd_addr(rd_addr),
    .stat_rd_ack(ack_m), .stat_rd_data(data_m), .stat_rd_ovf(ovf_m), .stat_rd_err(err_m)
  );

  // Narrow width so that counter wrap is reachable in a short run.
  rx_stat_counters #(.CNT_W(8), .CLR_ON_READ(1'b0)) dut_n (
    .rxclk(clk), .reset(reset), .rxStatRegPlus(plus), .rx_byte_count(nbytes),
    .stat_clear(sclr), .stat_rd_req(rd_req), .stat_rd_addr(rd_addr),
    .stat_rd_ack(ack_n), .stat_rd_data(data_n), .stat_rd_ovf(ovf_n), .stat_rd_err(err_n)
  );

  int total = 0;
  int bad   = 0;

  // Model: index 0 = wide clear-on-read instance, index 1 = narrow instance.
  longint unsigned mcnt [2][18];
  bit              movf [2][18];
  bit [17:0]       pend;
  longint unsigned pbytes;
  bit              exp_ack;
  bit              exp_err;
  longint unsigned exp_data [2];
  bit              exp_ovf [2];

  function automatic longint unsigned modulus(input int k);
    return (k == 0) ? (64'd1 << 48) : 64'd256;
  endfunction

  // Drive one cycle of stimulus, predict the read result, advance the model.
  task automatic cycle(input logic [17:0] inc, input logic [3:0] nb, input bit clr,
                       input bit rd, input logic [4:0] addr, input bit rst);
    bit              valid;
    bit              z;
    longint unsigned s;
    longint unsigned amt;
    reset   = rst;
    plus    = inc;
    nbytes  = nb;
    sclr    = clr;
    rd_req  = rd;
    rd_addr = addr;
    valid   = (addr < 5'd18) && (addr != 5'd13);
    exp_ack = rd && !rst;
    exp_err = exp_ack && !valid;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = (exp_ack && valid) ? mcnt[k][addr] : 64'd0;
      exp_ovf[k]  = exp_ack && valid && movf[k][addr];
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 18; i++) begin
        if (rst) begin
          mcnt[k][i] = 0;
          movf[k][i] = 1'b0;
        end else if (i != 13) begin
          z   = clr || (k == 0 && rd && valid && int'(addr) == i);
          amt = pend[i] ? ((i == 17) ? pbytes : 64'd1) : 64'd0;
          s   = (z ? 64'd0 : mcnt[k][i]) + amt;
          if (z) movf[k][i] = 1'b0;
          if (s >= modulus(k)) begin
            s          = s - modulus(k);
            movf[k][i] = 1'b1;
          end
          mcnt[k][i] = s;
        end
      end
    end
    pend   = rst ? 18'd0 : inc;
    pbytes = rst ? 64'd0 : 64'(nb);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(18'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic pulse(input logic [17:0] m, input logic [3:0] nb, input int n);
    repeat (n) cycle(m, nb, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(18'd0, 4'd0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic test_reset;
    bit e;
    cycle(18'h3FFFF, 4'd8, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle(18'h3FFFF, 4'd8, 1'b0, 1'b1, 5'd0, 1'b1);
    total++;
    if ({ack_m, ovf_m, err_m, ack_n, ovf_n, err_n} !== 6'd0 || data_m !== 48'd0 || data_n !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: ack=%b/%b ovf=%b/%b err=%b/%b data=%0d/%0d, want all 0",
               ack_m, ack_n, ovf_m, ovf_n, err_m, err_n, data_m, data_n);
    end
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      e = (a == 13) || (a > 17);
      total++;
      if (ack_m !== 1'b1 || data_m !== 48'd0 || ovf_m !== 1'b0 || err_m !== e ||
          ack_n !== 1'b1 || data_n !== 8'd0 || ovf_n !== 1'b0 || err_n !== e) begin
        bad++;
        $display("FAIL reset_read a=%0d: ack=%b/%b data=%0d/%0d ovf=%b/%b err=%b/%b, want ack=1 data=0 ovf=0 err=%b",
                 a, ack_m, ack_n, data_m, data_n, ovf_m, ovf_n, err_m, err_n, e);
      end
    end
  endtask

  task automatic test_latency;
    pulse(18'h1, 4'd0, 5);
    idle(1);
    rd(5'd0);
    total++;
    if (data_m !== 48'd5 || data_n !== 8'd5 || ack_m !== 1'b1) begin
      bad++;
      $display("FAIL latency_full: data=%0d/%0d ack=%b, want 5/5 ack=1", data_m, data_n, ack_m);
    end
    cycle(18'd0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    pulse(18'h1, 4'd0, 5);
    rd(5'd0);
    total++;
    if (data_m !== 48'd4 || data_n !== 8'd4) begin
      bad++;
      $display("FAIL latency_early: data=%0d/%0d, want 4/4", data_m, data_n);
    end
    rd(5'd0);
    total++;
    if (data_m !== 48'd1 || data_n !== 8'd5) begin
      bad++;
      $display("FAIL latency_cor: data=%0d/%0d, want 1/5", data_m, data_n);
    end
  endtask

  task automatic test_bytes;
    pulse(18'h20000, 4'd8, 2);
    pulse(18'h20000, 4'd3, 1);
    pulse(18'h00000, 4'd7, 1);
    idle(1);
    rd(5'd17);
    total++;
    if (data_m !== 48'd19 || data_n !== 8'd19 || err_m !== 1'b0) begin
      bad++;
      $display("FAIL bytes: data=%0d/%0d err=%b, want 19/19 err=0", data_m, data_n, err_m);
    end
  endtask

  task automatic test_clr_on_read;
    pulse(18'h4, 4'd0, 7);
    idle(1);
    pulse(18'h4, 4'd0, 1);
    rd(5'd2);
    total++;
    if (data_m !== 48'd7 || data_n !== 8'd7) begin
      bad++;
      $display("FAIL cor_first: data=%0d/%0d, want 7/7", data_m, data_n);
    end
    rd(5'd2);
    total++;
    if (data_m !== 48'd1 || data_n !== 8'd8) begin
      bad++;
      $display("FAIL cor_second: data=%0d/%0d, want 1/8", data_m, data_n);
    end
  endtask

  task automatic test_clear_read;
    pulse(18'h200, 4'd0, 12);
    idle(1);
    cycle(18'd0, 4'd0, 1'b1, 1'b1, 5'd9, 1'b0);
    total++;
    if (data_m !== 48'd12 || data_n !== 8'd12) begin
      bad++;
      $display("FAIL clear_read_pre: data=%0d/%0d, want 12/12", data_m, data_n);
    end
    rd(5'd9);
    total++;
    if (data_m !== 48'd0 || data_n !== 8'd0 || ovf_m !== 1'b0 || ovf_n !== 1'b0) begin
      bad++;
      $display("FAIL clear_read_post: data=%0d/%0d ovf=%b/%b, want 0/0 ovf 0/0", data_m, data_n, ovf_m, ovf_n);
    end
  endtask

  task automatic test_wrap;
    cycle(18'd0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    pulse(18'h20, 4'd0, 255);
    idle(1);
    rd(5'd5);
    total++;
    if (data_n !== 8'd255 || ovf_n !== 1'b0 || data_m !== 48'd255) begin
      bad++;
      $display("FAIL wrap_full: data=%0d/%0d ovf_n=%b, want 255/255 ovf 0", data_m, data_n, ovf_n);
    end
    pulse(18'h20, 4'd0, 1);
    idle(1);
    rd(5'd5);
    total++;
    if (data_n !== 8'd0 || ovf_n !== 1'b1 || data_m !== 48'd1 || ovf_m !== 1'b0) begin
      bad++;
      $display("FAIL wrap_carry: data=%0d/%0d ovf=%b/%b, want 1/0 ovf 0/1", data_m, data_n, ovf_m, ovf_n);
    end
    pulse(18'h20, 4'd0, 3);
    idle(1);
    rd(5'd5);
    total++;
    if (data_n !== 8'd3 || ovf_n !== 1'b1) begin
      bad++;
      $display("FAIL wrap_sticky: data=%0d ovf=%b, want 3 ovf 1", data_n, ovf_n);
    end
    cycle(18'd0, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    rd(5'd5);
    total++;
    if (data_n !== 8'd0 || ovf_n !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear: data=%0d ovf=%b, want 0 ovf 0", data_n, ovf_n);
    end
  endtask

  task automatic test_reset_mid_read;
    pulse(18'h2, 4'd0, 1);
    cycle(18'h2, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1);
    total++;
    if (ack_m !== 1'b0 || ack_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_ack: ack=%b/%b, want 0/0", ack_m, ack_n);
    end
    idle(2);
    rd(5'd1);
    total++;
    if (data_m !== 48'd0 || data_n !== 8'd0 || ack_m !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_drop: data=%0d/%0d ack=%b, want 0/0 ack=1", data_m, data_n, ack_m);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 1500; n++) begin
      cycle(18'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
      total++;
      if (ack_m !== exp_ack || ack_n !== exp_ack) begin
        bad++;
        $display("FAIL rand_ack n=%0d: ack=%b/%b, want %b", n, ack_m, ack_n, exp_ack);
      end
      if (exp_ack) begin
        total++;
        if (64'(data_m) !== exp_data[0] || ovf_m !== exp_ovf[0] || err_m !== exp_err) begin
          bad++;
          $display("FAIL rand_wide n=%0d addr=%0d: data=%0d ovf=%b err=%b, want %0d ovf=%b err=%b",
                   n, rd_addr, data_m, ovf_m, err_m, exp_data[0], exp_ovf[0], exp_err);
        end
        total++;
        if (64'(data_n) !== exp_data[1] || ovf_n !== exp_ovf[1] || err_n !== exp_err) begin
          bad++;
          $display("FAIL rand_narrow n=%0d addr=%0d: data=%0d ovf=%b err=%b, want %0d ovf=%b err=%b",
                   n, rd_addr, data_n, ovf_n, err_n, exp_data[1], exp_ovf[1], exp_err);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    plus    = '0;
    nbytes  = '0;
    sclr    = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    pend    = '0;
    pbytes  = 0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_bytes();
    test_clr_on_read();
    test_clear_read();
    test_wrap();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
